mic_fir_mac: RTL and testbench

Streaming FIR datapath for the microphone filter chain. It is the read-side consumer of a coefficient RAM's second port, which the host fills over PCIe. For every accepted audio sample it shifts the sample into a register-based history line and fetches all coefficients through the RAM port. It then multiply-accumulates them against the history and emits one scaled, saturated output sample. Control comes from the 32-bit `micfilter_cntl` word and the `micfilter_rst` soft reset.

---
 rtl/mic_fir_mac_if.sv | 33 +++
 rtl/mic_fir_mac.sv | 184 ++++++++++++++++++
 tb/tb_mic_fir_mac.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mic_fir_mac_if.sv
// Sample stream, control and coefficient-RAM read port of mic_fir_mac.
// master is the host/RAM side; slave is the filter datapath.
interface mic_fir_mac_if #(
  parameter int unsigned ADDR_W = 9
);
  logic [31:0]       cntl;
  logic              filt_rst;
  logic              in_valid;
  logic [15:0]       in_data;
  logic              in_ready;
  logic              out_valid;
  logic [15:0]       out_data;
  logic              overrun;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_clken;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_readdata;

  modport master (
    output cntl, filt_rst, in_valid, in_data, mem_readdata,
    input  in_ready, out_valid, out_data, overrun,
    input  mem_address, mem_chipselect, mem_clken, mem_write, mem_writedata, mem_byteenable
  );

  modport slave (
    input  cntl, filt_rst, in_valid, in_data, mem_readdata,
    output in_ready, out_valid, out_data, overrun,
    output mem_address, mem_chipselect, mem_clken, mem_write, mem_writedata, mem_byteenable
  );
endinterface

// File: rtl/mic_fir_mac.sv
// Streaming FIR for the microphone chain: per accepted sample, fetches NTAPS
// coefficients from a RAM read port and MACs them against a register history.
module mic_fir_mac #(
  parameter int unsigned NTAPS     = 64,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned COEF_BASE = 0,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned ACC_W     = 40
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  mic_fir_mac_if.slave  bus
);

  localparam int unsigned IDX_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(NTAPS - 1);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(COEF_BASE);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t                   state;
  logic signed [15:0]       hist [NTAPS];
  logic [4:0]               sh;
  logic [IDX_W-1:0]         tap;
  logic [RD_LAT-1:0]        rp_vld;
  logic [RD_LAT-1:0]        rp_last;
  logic [IDX_W-1:0]         rp_idx [RD_LAT];
  logic signed [31:0]       prod;
  logic                     prod_vld;
  logic                     prod_last;
  logic signed [ACC_W-1:0]  acc;

  logic signed [15:0]       coef_c;
  logic signed [ACC_W-1:0]  acc_sum_c;
  logic signed [ACC_W-1:0]  shifted_c;
  logic signed [15:0]       sat_c;
  logic                     unused_bits;

  assign coef_c      = bus.mem_readdata[15:0];
  assign unused_bits = ^{bus.cntl[31:6], bus.mem_readdata[31:16]};

  // Final sum includes the product still in flight, so the result is ready
  // on the same edge that retires the last tap.
  always_comb begin
    acc_sum_c = acc + ACC_W'(prod);
    shifted_c = acc_sum_c >>> sh;
    sat_c     = shifted_c[15:0];
    if (shifted_c > SAT_MAX) begin
      sat_c = 16'sh7fff;
    end else if (shifted_c < SAT_MIN) begin
      sat_c = 16'sh8000;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state              <= S_IDLE;
      for (int i = 0; i < int'(NTAPS); i++) hist[i] <= '0;
      sh                 <= '0;
      tap                <= '0;
      rp_vld             <= '0;
      rp_last            <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) rp_idx[i] <= '0;
      prod               <= '0;
      prod_vld           <= 1'b0;
      prod_last          <= 1'b0;
      acc                <= '0;
      bus.in_ready       <= 1'b1;
      bus.out_valid      <= 1'b0;
      bus.out_data       <= '0;
      bus.overrun        <= 1'b0;
      bus.mem_address    <= BASE_ADDR;
      bus.mem_chipselect <= 1'b0;
      bus.mem_clken      <= 1'b0;
      bus.mem_write      <= 1'b0;
      bus.mem_writedata  <= '0;
      bus.mem_byteenable <= 4'hF;
    end else begin
      bus.mem_clken      <= 1'b1;
      bus.mem_write      <= 1'b0;
      bus.mem_writedata  <= '0;
      bus.mem_byteenable <= 4'hF;
      bus.out_valid      <= 1'b0;

      if (bus.filt_rst) begin
        // Soft clear drops everything in flight, including a same-cycle sample.
        state              <= S_IDLE;
        for (int i = 0; i < int'(NTAPS); i++) hist[i] <= '0;
        tap                <= '0;
        rp_vld             <= '0;
        rp_last            <= '0;
        prod               <= '0;
        prod_vld           <= 1'b0;
        prod_last          <= 1'b0;
        acc                <= '0;
        bus.in_ready       <= 1'b1;
        bus.overrun        <= 1'b0;
        bus.mem_address    <= BASE_ADDR;
        bus.mem_chipselect <= 1'b0;
      end else begin
        // Read-return pipeline tags each returning word with its tap index.
        rp_vld[0]  <= bus.mem_chipselect;
        rp_last[0] <= bus.mem_chipselect && (tap == LAST_TAP);
        rp_idx[0]  <= tap;
        for (int i = 1; i < int'(RD_LAT); i++) begin
          rp_vld[i]  <= rp_vld[i-1];
          rp_last[i] <= rp_last[i-1];
          rp_idx[i]  <= rp_idx[i-1];
        end

        prod_vld  <= rp_vld[RD_LAT-1];
        prod_last <= rp_last[RD_LAT-1];
        if (rp_vld[RD_LAT-1]) begin
          prod <= 32'(coef_c) * 32'(hist[rp_idx[RD_LAT-1]]);
        end
        if (prod_vld) begin
          acc <= acc_sum_c;
        end

        if (bus.in_valid && !bus.in_ready) begin
          bus.overrun <= 1'b1;
        end

        case (state)
          S_IDLE: begin
            if (bus.in_valid) begin
              if (bus.cntl[0]) begin
                hist[0] <= bus.in_data;
                for (int i = 1; i < int'(NTAPS); i++) hist[i] <= hist[i-1];
                sh                 <= bus.cntl[5:1];
                acc                <= '0;
                tap                <= '0;
                bus.mem_address    <= BASE_ADDR;
                bus.mem_chipselect <= 1'b1;
                bus.in_ready       <= 1'b0;
                state              <= S_FETCH;
              end else begin
                bus.out_data  <= bus.in_data;
                bus.out_valid <= 1'b1;
              end
            end
          end

          S_FETCH: begin
            if (tap == LAST_TAP) begin
              bus.mem_address    <= BASE_ADDR;
              bus.mem_chipselect <= 1'b0;
              state              <= S_DRAIN;
            end else begin
              tap             <= tap + IDX_W'(1);
              bus.mem_address <= ADDR_W'(COEF_BASE + 32'(tap) + 32'd1);
            end
          end

          S_DRAIN: begin
            if (prod_vld && prod_last) begin
              bus.out_data  <= sat_c;
              bus.out_valid <= 1'b1;
              state         <= S_OUT;
            end
          end

          S_OUT: begin
            bus.in_ready <= 1'b1;
            state        <= S_IDLE;
          end

          default: begin
            bus.in_ready <= 1'b1;
            state        <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mic_fir_mac.sv
// Bench for mic_fir_mac: two instances (RD_LAT 1 and 2) share stimulus and a
// coefficient RAM image; each is compared every cycle against a timing model.
module tb_mic_fir_mac;

  localparam int unsigned NTAPS     = 64;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned COEF_BASE = 8;
  localparam int unsigned ACC_W     = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cntl;
  logic        filt_rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic [31:0] ram [1 << ADDR_W];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int inst, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s inst%0d actual=%0d required=%0d at %0t", nm, inst, act, exp, $time);
    end
  endtask

  // Direct-form FIR from the RAM image: sum, arithmetic shift, clamp.
  function automatic longint fir_model(input logic signed [15:0] h [NTAPS], input int shv);
    longint s;
    logic [31:0] w;
    logic signed [15:0] c;
    s = 0;
    for (int k = 0; k < int'(NTAPS); k++) begin
      w = ram[COEF_BASE + k];
      c = w[15:0];
      s += longint'(c) * longint'(h[k]);
    end
    s = s >>> shv;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return s;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned RL = g + 1;
    localparam int OUTC = int'(NTAPS) + int'(RL) + 2;

    mic_fir_mac_if #(.ADDR_W(ADDR_W)) bus ();

    assign bus.cntl     = cntl;
    assign bus.filt_rst = filt_rst;
    assign bus.in_valid = in_valid;
    assign bus.in_data  = in_data;

    logic [31:0] rd [RL];
    always @(posedge clk) begin
      rd[0] <= (bus.mem_chipselect && bus.mem_clken) ? ram[bus.mem_address] : $urandom;
      for (int i = 1; i < int'(RL); i++) rd[i] <= rd[i-1];
    end
    assign bus.mem_readdata = rd[RL-1];

    mic_fir_mac #(
      .NTAPS(NTAPS), .ADDR_W(ADDR_W), .COEF_BASE(COEF_BASE), .RD_LAT(RL), .ACC_W(ACC_W)
    ) dut (
      .clk_clk      (clk),
      .reset_reset_n(rst_n),
      .bus          (bus)
    );

    int                 cyc      = 0;
    int                 acc_t    = -1;
    int                 byp_t    = -1;
    longint             exp_val  = 0;
    longint             byp_val  = 0;
    longint             exp_last = 0;
    bit                 ov       = 1'b0;
    bit                 prev_rst = 1'b0;
    logic signed [15:0] mh [NTAPS];

    always @(negedge clk) begin
      bit     busy, fetch, e_oval;
      longint e_od, e_addr;
      if (!rst_n) begin
        chk("rst_in_ready", g, longint'(bus.in_ready), 1);
        chk("rst_out_valid", g, longint'(bus.out_valid), 0);
        chk("rst_out_data", g, longint'(bus.out_data), 0);
        chk("rst_overrun", g, longint'(bus.overrun), 0);
        chk("rst_cs", g, longint'(bus.mem_chipselect), 0);
        chk("rst_addr", g, longint'(bus.mem_address), longint'(COEF_BASE));
        chk("rst_clken", g, longint'(bus.mem_clken), 0);
        acc_t = -1; byp_t = -1; ov = 1'b0; prev_rst = 1'b0;
        for (int k = 0; k < int'(NTAPS); k++) mh[k] = '0;
      end else begin
        busy   = (acc_t >= 0) && (cyc > acc_t) && (cyc <= acc_t + OUTC);
        fetch  = (acc_t >= 0) && (cyc > acc_t) && (cyc <= acc_t + int'(NTAPS));
        e_oval = ((acc_t >= 0) && (cyc == acc_t + OUTC)) || ((byp_t >= 0) && (cyc == byp_t + 1));
        e_od   = ((acc_t >= 0) && (cyc == acc_t + OUTC)) ? exp_val : byp_val;
        e_addr = fetch ? longint'(COEF_BASE + cyc - acc_t - 1) : longint'(COEF_BASE);

        chk("in_ready", g, longint'(bus.in_ready), longint'(!busy));
        chk("out_valid", g, longint'(bus.out_valid), longint'(e_oval));
        if (e_oval) chk("out_data", g, longint'($signed(bus.out_data)), e_od);
        chk("overrun", g, longint'(bus.overrun), longint'(ov));
        chk("mem_chipselect", g, longint'(bus.mem_chipselect), longint'(fetch));
        chk("mem_address", g, longint'(bus.mem_address), e_addr);
        chk("mem_clken", g, longint'(bus.mem_clken), longint'(prev_rst));
        chk("mem_write", g, longint'(bus.mem_write), 0);
        chk("mem_writedata", g, longint'(bus.mem_writedata), 0);
        chk("mem_byteenable", g, longint'(bus.mem_byteenable), 15);
        prev_rst = 1'b1;

        if (filt_rst) begin
          acc_t = -1; byp_t = -1; ov = 1'b0;
          for (int k = 0; k < int'(NTAPS); k++) mh[k] = '0;
        end else if (in_valid) begin
          if (busy) begin
            ov = 1'b1;
          end else if (cntl[0]) begin
            for (int k = int'(NTAPS) - 1; k > 0; k--) mh[k] = mh[k-1];
            mh[0]    = in_data;
            exp_val  = fir_model(mh, int'(cntl[5:1]));
            exp_last = exp_val;
            acc_t    = cyc;
          end else begin
            byp_t   = cyc;
            byp_val = longint'($signed(in_data));
          end
        end
        cyc++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic soft_clear();
    filt_rst = 1'b1;
    step(1);
    filt_rst = 1'b0;
  endtask

  // Presents one sample and waits for both instances to emit their result.
  task automatic send(input logic [15:0] d, output int lat0, output int lat1,
                      output int od0, output int od1);
    in_valid = 1'b1;
    in_data  = d;
    lat0 = -1; lat1 = -1; od0 = 0; od1 = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (lat0 < 0 && g_inst[0].bus.out_valid) begin
        lat0 = n; od0 = int'($signed(g_inst[0].bus.out_data));
      end
      if (lat1 < 0 && g_inst[1].bus.out_valid) begin
        lat1 = n; od1 = int'($signed(g_inst[1].bus.out_data));
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (lat0 >= 0 && lat1 >= 0) break;
    end
    if (lat0 < 0 || lat1 < 0) chk("result_within_bound", 0, longint'(lat0 >= 0 && lat1 >= 0), 1);
  endtask

  task automatic load_ramp();
    for (int k = 0; k < int'(NTAPS); k++) ram[COEF_BASE + k] = {16'($urandom), 16'(k + 1)};
  endtask

  initial begin
    int lat0, lat1, od0, od1, cnt;
    for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = $urandom;
    rst_n = 1'b0; cntl = '0; filt_rst = 1'b0; in_valid = 1'b0; in_data = '0;
    step(3);
    rst_n = 1'b1;
    step(2);

    // Impulse through a ramp of coefficients.
    load_ramp();
    cntl = {26'($urandom), 5'd0, 1'b1};
    for (int i = 0; i < int'(NTAPS); i++) begin
      send((i == 0) ? 16'd1 : 16'd0, lat0, lat1, od0, od1);
      chk("impulse_latency_rd1", 0, lat0, 67);
      chk("impulse_latency_rd2", 1, lat1, 68);
      chk("impulse_value", 0, od0, i + 1);
      chk("impulse_value", 1, od1, i + 1);
      if (i == 0) chk("model_impulse_first", 0, g_inst[0].exp_last, 1);
      if (i == int'(NTAPS) - 1) chk("model_impulse_last", 0, g_inst[0].exp_last, 64);
    end

    // Random coefficients, samples, shifts, and occasional bypass.
    for (int t = 0; t < 24; t++) begin
      if (t % 8 == 0)
        for (int k = 0; k < int'(NTAPS); k++) ram[COEF_BASE + k] = $urandom;
      cntl = $urandom;
      cntl[0] = ($urandom_range(0, 5) != 0);
      cntl[5:1] = 5'($urandom_range(0, 18));
      send(16'($urandom), lat0, lat1, od0, od1);
    end

    // Saturation at both rails, then a pure shift.
    soft_clear();
    for (int k = 0; k < int'(NTAPS); k++) ram[COEF_BASE + k] = {16'($urandom), 16'h7fff};
    cntl = 32'd1;
    for (int i = 0; i < int'(NTAPS); i++) send(16'h7fff, lat0, lat1, od0, od1);
    chk("sat_pos", 0, od0, 32767);
    chk("sat_pos", 1, od1, 32767);
    chk("model_sat_pos", 0, g_inst[0].exp_last, 32767);
    soft_clear();
    for (int i = 0; i < int'(NTAPS); i++) send(16'h8000, lat0, lat1, od0, od1);
    chk("sat_neg", 0, od0, -32768);
    chk("sat_neg", 1, od1, -32768);
    soft_clear();
    cntl = {26'd0, 5'd21, 1'b1};
    send(16'h7fff, lat0, lat1, od0, od1);
    chk("shift21", 0, od0, 511);
    chk("shift21", 1, od1, 511);
    chk("model_shift21", 0, g_inst[0].exp_last, 511);

    // Overrun: sample 10 cycles into a computation, enable dropped meanwhile.
    load_ramp();
    soft_clear();
    cntl = 32'd1;
    in_valid = 1'b1; in_data = 16'd5;
    step(1);
    in_valid = 1'b0; cntl = 32'd0;
    step(9);
    in_valid = 1'b1; in_data = 16'd777;
    step(1);
    in_valid = 1'b0;
    step(70);
    cntl = 32'd1;
    chk("overrun_set", 0, longint'(g_inst[0].bus.overrun), 1);
    chk("overrun_set", 1, longint'(g_inst[1].bus.overrun), 1);
    chk("model_overrun_result", 0, g_inst[0].exp_last, 5);
    soft_clear();
    chk("overrun_cleared", 0, longint'(g_inst[0].bus.overrun), 0);
    chk("overrun_cleared", 1, longint'(g_inst[1].bus.overrun), 0);

    // Soft reset in the middle of the fetch.
    in_valid = 1'b1; in_data = 16'd3;
    step(1);
    in_valid = 1'b0;
    step(30);
    filt_rst = 1'b1;
    step(1);
    filt_rst = 1'b0;
    chk("ready_after_soft_rst", 0, longint'(g_inst[0].bus.in_ready), 1);
    chk("ready_after_soft_rst", 1, longint'(g_inst[1].bus.in_ready), 1);
    cnt = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      cnt += int'(g_inst[0].bus.out_valid) + int'(g_inst[1].bus.out_valid);
    end
    step(1);
    chk("no_result_after_soft_rst", 0, cnt, 0);
    send(16'd1, lat0, lat1, od0, od1);
    chk("fresh_history", 0, od0, 1);
    chk("fresh_history", 1, od1, 1);

    // Bypass leaves the history alone.
    cntl = 32'd0;
    send(16'h1234, lat0, lat1, od0, od1);
    chk("bypass_latency", 0, lat0, 1);
    chk("bypass_value", 0, od0, 32'h1234);
    chk("bypass_value", 1, od1, 32'h1234);
    cntl = 32'd1;
    send(16'd0, lat0, lat1, od0, od1);
    chk("after_bypass", 0, od0, 2);
    chk("after_bypass", 1, od1, 2);

    // Hard reset mid-fetch discards the result and clears the history.
    in_valid = 1'b1; in_data = 16'd9;
    step(1);
    in_valid = 1'b0;
    step(20);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(80);
    send(16'd1, lat0, lat1, od0, od1);
    chk("after_hard_rst", 0, od0, 1);
    chk("after_hard_rst", 1, od1, 1);
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
